// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall sequencer for the five-stage pipeline. This is the only
// source of the enable and nop-insert controls for the PC register, the F/D
// latch and the D/X latch. It does three things:
//   - inserts a one-cycle bubble when a load in D/X feeds the instruction in F/D
//   - flushes the two younger instructions when X resolves a taken branch
//   - freezes the front of the pipeline while the multicycle mult/div unit runs
//
// Optional feature: define STALL_PERF_EN to add the 32-bit stall_cnt port and
// its counter. Without the macro the port and the counter do not exist.
//
// Parameters
//   MD_TIMEOUT  maximum MD_WAIT cycles before md_err is raised
//   CNT_W       width of the mult/div wait counter (must hold MD_TIMEOUT)
//
// Ports
//   clock         in   pipeline clock, rising edge
//   clrn          in   synchronous active-low reset
//   fd_ir  [31:0] in   instruction in the F/D latch
//   dx_ir  [31:0] in   instruction in the D/X latch
//   branch_taken  in   X resolved a taken branch/jump this cycle
//   md_ready      in   mult/div result valid (one-cycle pulse)
//   pc_en         out  PC register enable            (combinational)
//   fd_en         out  F/D latch enable              (combinational)
//   dx_en         out  D/X latch enable              (combinational)
//   fd_nop        out  load nop into F/D on this edge (combinational)
//   dx_nop        out  load nop into D/X on this edge (combinational)
//   md_start      out  one-cycle start pulse to mult/div (registered)
//   md_err        out  sticky mult/div timeout flag      (registered)
//   stall_cnt     out  stall-cycle counter, STALL_PERF_EN only (registered)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        fd_nop,
    output logic        dx_nop,
    output logic        md_start,
    output logic        md_err
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MD_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             start_nxt;
    logic             timeout_hit;
    logic             load_use;
    logic             dx_is_md;

    function automatic logic is_lw(input logic [31:0] ir);
        return ir[31:27] == 5'b01000;
    endfunction

    function automatic logic is_muldiv(input logic [31:0] ir);
        return (ir[31:27] == 5'b00000) &&
               ((ir[6:2] == 5'b00110) || (ir[6:2] == 5'b00111));
    endfunction

    // Register fields outside opcode/rd/rs/rt/ALU op play no part in hazard
    // detection.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{fd_ir[31:22], fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    // A load writing r0 never creates a dependency, since r0 is hardwired.
    assign load_use = is_lw(dx_ir) && (dx_ir[26:22] != 5'd0) &&
                      ((dx_ir[26:22] == fd_ir[21:17]) ||
                       (dx_ir[26:22] == fd_ir[16:12]));

    assign dx_is_md = is_muldiv(dx_ir);

    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        dx_en        = 1'b1;
        fd_nop       = 1'b0;
        dx_nop       = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = '0;
        start_nxt    = 1'b0;
        timeout_hit  = 1'b0;

        if (!clrn) begin
            // Hold every latch loading nops for as long as reset is asserted.
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            fd_nop    = 1'b1;
            dx_nop    = 1'b1;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        fd_nop = 1'b1;
                        dx_nop = 1'b1;
                    end else if (dx_is_md) begin
                        // Freeze everything so the mul/div stays parked in D/X.
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        start_nxt = 1'b1;
                        state_nxt = MD_WAIT;
                    end else if (load_use) begin
                        // The nop entering D/X clears the hazard next cycle.
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_nop = 1'b1;
                    end
                end

                MD_WAIT: begin
                    pc_en = 1'b0;
                    fd_en = 1'b0;
                    dx_en = 1'b0;
                    // md_start is still high in the first wait cycle; a ready
                    // seen then belongs to no operation of ours.
                    if (md_ready && !md_start) begin
                        state_nxt = MD_DRAIN;
                    end else if (wait_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        timeout_hit = 1'b1;
                        state_nxt   = MD_DRAIN;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end

                MD_DRAIN: begin
                    // The mul/div moves on to X; D/X is backfilled with a nop.
                    dx_nop    = 1'b1;
                    state_nxt = RUN;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            state    <= RUN;
            wait_cnt <= '0;
            md_start <= 1'b0;
            md_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            md_start <= start_nxt;
            if (timeout_hit) begin
                md_err <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clock) begin
        if (!clrn) begin
            stall_cnt <= 32'd0;
        end else if (!pc_en) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. The bench plays the role of the
// pipeline latches: it drives fd_ir/dx_ir directly and advances them by hand
// the way the latches would, given the enables it just observed.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] LW_R5        = 32'h4140_0000; // lw  r5
    localparam logic [31:0] LW_R0        = 32'h4000_0000; // lw  r0
    localparam logic [31:0] ADD_R1_R5_R2 = 32'h004A_2000; // add r1, r5, r2
    localparam logic [31:0] ADD_R1_R2_R5 = 32'h0044_5000; // add r1, r2, r5
    localparam logic [31:0] ADD_R1_R2_R3 = 32'h0044_3000; // add r1, r2, r3
    localparam logic [31:0] ADD_R1_R0_R0 = 32'h0040_0000; // add r1, r0, r0
    localparam logic [31:0] MUL_R3_R1_R2 = 32'h00C2_2018; // mul r3, r1, r2
    localparam logic [31:0] DIV_R4_R1_R2 = 32'h0102_201C; // div r4, r1, r2

    logic        clock = 1'b0;
    logic        clrn;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_taken;
    logic        md_ready;
    logic        pc_en;
    logic        fd_en;
    logic        dx_en;
    logic        fd_nop;
    logic        dx_nop;
    logic        md_start;
    logic        md_err;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .MD_TIMEOUT (40),
        .CNT_W      (6)
    ) dut (
        .clock        (clock),
        .clrn         (clrn),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .fd_nop       (fd_nop),
        .dx_nop       (dx_nop),
        .md_start     (md_start),
        .md_err       (md_err)
`ifdef STALL_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        clrn         = 1'b0;
        fd_ir        = NOP;
        dx_ir        = NOP;
        branch_taken = 1'b0;
        md_ready     = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int nzero;
        int n;
        logic err_early;

        // ---------------- reset hold ----------------
        do_reset();
        settle();
        check("rst_pc_en",  pc_en,  1'b0);
        check("rst_fd_en",  fd_en,  1'b0);
        check("rst_dx_en",  dx_en,  1'b0);
        check("rst_fd_nop", fd_nop, 1'b1);
        check("rst_dx_nop", dx_nop, 1'b1);
        check("rst_md_err", md_err, 1'b0);
        check("rst_md_start", md_start, 1'b0);
`ifdef STALL_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        clrn = 1'b1;
        settle();
        check("run_pc_en",  pc_en,  1'b1);
        check("run_dx_nop", dx_nop, 1'b0);
        tick();

        // ---------------- load-use bubble ----------------
        dx_ir = LW_R5;
        fd_ir = ADD_R1_R5_R2;
        settle();
        check("lu_pc_en",  pc_en,  1'b0);
        check("lu_fd_en",  fd_en,  1'b0);
        check("lu_dx_en",  dx_en,  1'b1);
        check("lu_dx_nop", dx_nop, 1'b1);
        check("lu_fd_nop", fd_nop, 1'b0);
        tick();
        dx_ir = NOP;  // the bubble now sits in D/X, add still in F/D
        settle();
        check("lu_next_pc_en",  pc_en,  1'b1);
        check("lu_next_fd_en",  fd_en,  1'b1);
        check("lu_next_dx_nop", dx_nop, 1'b0);
`ifdef STALL_PERF_EN
        check("lu_stall_cnt", stall_cnt, 32'd1);
`endif
        tick();

        // dependency through rt
        dx_ir = LW_R5;
        fd_ir = ADD_R1_R2_R5;
        settle();
        check("lu_rt_pc_en", pc_en, 1'b0);
        tick();
        dx_ir = NOP;

        // a load into r0 never stalls
        dx_ir = LW_R0;
        fd_ir = ADD_R1_R0_R0;
        settle();
        check("lu_r0_pc_en",  pc_en,  1'b1);
        check("lu_r0_dx_nop", dx_nop, 1'b0);

        // load with no matching source
        dx_ir = LW_R5;
        fd_ir = ADD_R1_R2_R3;
        settle();
        check("lu_nomatch_pc_en", pc_en, 1'b1);
        tick();

        // ---------------- branch priority ----------------
        dx_ir        = LW_R5;
        fd_ir        = ADD_R1_R5_R2;
        branch_taken = 1'b1;
        settle();
        check("br_fd_nop", fd_nop, 1'b1);
        check("br_dx_nop", dx_nop, 1'b1);
        check("br_pc_en",  pc_en,  1'b1);
        check("br_fd_en",  fd_en,  1'b1);
        check("br_dx_en",  dx_en,  1'b1);
        // a branch also squashes a mul/div sitting in D/X
        dx_ir = MUL_R3_R1_R2;
        settle();
        check("br_md_pc_en",  pc_en,  1'b1);
        check("br_md_dx_nop", dx_nop, 1'b1);
        tick();
        check("br_md_no_start", md_start, 1'b0);
`ifdef STALL_PERF_EN
        check("br_stall_cnt", stall_cnt, 32'd2);
`endif
        branch_taken = 1'b0;
        dx_ir        = NOP;

        // ---------------- mul with md_ready in the 17th wait cycle ----------------
        do_reset();
        clrn  = 1'b1;
        fd_ir = ADD_R1_R5_R2;
        dx_ir = MUL_R3_R1_R2;
        settle();
        nzero = 0;
        check("md_issue_pc_en", pc_en, 1'b0);
        check("md_issue_fd_en", fd_en, 1'b0);
        check("md_issue_dx_en", dx_en, 1'b0);
        check("md_issue_start", md_start, 1'b0);
        if (!pc_en) nzero++;
        tick();
        // first wait cycle: md_start high, a ready pulse here must be ignored
        md_ready = 1'b1;
        settle();
        check("md_start_w1", md_start, 1'b1);
        if (!pc_en) nzero++;
        for (int w = 2; w <= 17; w++) begin
            tick();
            md_ready = (w == 17);
            settle();
            if (w == 2) check("md_start_w2", md_start, 1'b0);
            if (!pc_en) nzero++;
        end
        tick();
        md_ready = 1'b0;
        settle();
        if (!pc_en) nzero++;
        check("md_drain_pc_en",  pc_en,  1'b1);
        check("md_drain_fd_en",  fd_en,  1'b1);
        check("md_drain_dx_en",  dx_en,  1'b1);
        check("md_drain_dx_nop", dx_nop, 1'b1);
        check("md_drain_fd_nop", fd_nop, 1'b0);
        check("md_drain_err",    md_err, 1'b0);
        check("md_stall_cycles", nzero, 18);
        tick();
        dx_ir = NOP;
        settle();
        check("md_run_pc_en",  pc_en,  1'b1);
        check("md_run_dx_nop", dx_nop, 1'b0);
`ifdef STALL_PERF_EN
        check("md_stall_cnt", stall_cnt, 32'd18);
`endif
        tick();

        // ---------------- timeout: md_ready never comes ----------------
        dx_ir = MUL_R3_R1_R2;
        settle();
        check("to_issue_pc_en", pc_en, 1'b0);
        tick();
        settle();
        n         = 0;
        err_early = 1'b0;
        while (!pc_en && n < 60) begin
            n++;
            if (md_err) err_early = 1'b1;
            tick();
            settle();
        end
        check("to_wait_cycles", n, 40);
        check("to_err_early",   err_early, 1'b0);
        check("to_drain_pc_en", pc_en,  1'b1);
        check("to_drain_dx_nop", dx_nop, 1'b1);
        check("to_err_set",     md_err, 1'b1);
        tick();
        dx_ir = NOP;
        settle();
        check("to_run_pc_en",  pc_en,  1'b1);
        check("to_run_dx_nop", dx_nop, 1'b0);
        repeat (3) tick();
        check("to_err_sticky", md_err, 1'b1);

        // ---------------- reset in the 5th wait cycle ----------------
        do_reset();
        check("rw_err_cleared", md_err, 1'b0);
        clrn  = 1'b1;
        dx_ir = DIV_R4_R1_R2;
        settle();
        check("rw_issue_pc_en", pc_en, 1'b0);
        tick();
        settle();
        check("rw_start_w1", md_start, 1'b1);
        repeat (4) tick();
        clrn = 1'b0;
        settle();
        check("rw_hold_pc_en",  pc_en,  1'b0);
        check("rw_hold_fd_nop", fd_nop, 1'b1);
        check("rw_hold_dx_nop", dx_nop, 1'b1);
        tick();
        check("rw_md_start", md_start, 1'b0);
        check("rw_wait_cnt", dut.wait_cnt, 32'd0);
        check("rw_md_err",   md_err, 1'b0);
        clrn  = 1'b1;
        dx_ir = NOP;
        settle();
        check("rw_run_pc_en",  pc_en,  1'b1);
        check("rw_run_dx_nop", dx_nop, 1'b0);
        tick();
        check("rw_no_start", md_start, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
